spi_frame_loader: RTL and testbench
===================================

# spi_frame_loader

Command decoder between the SPI slave byte interface and the screen RAM write port. It parses SPI transactions framed by chip select into framebuffer writes: streamed byte writes at an auto-incrementing address, or a hardware fill of the whole framebuffer with one byte. It drives the RAM write address, write data and write enable directly, with one write per clock at most. The video read side is untouched.

## Interface
Parameters:
- FB_BYTES, 38400, framebuffer size in bytes (640×480 / 8); valid addresses 0..FB_BYTES-1
- ADDR_W, 16, address width; FB_BYTES ≤ 2^ADDR_W

Ports:
- clk  in  1  main clock (RAM clock domain)
- rst  in  1  asynchronous, active-high reset
- cs_n  in  1  raw SPI chip select, active low; asynchronous, synchronised internally by 2 flops
- rx_valid  in  1  one-cycle pulse, rx_byte valid (already in clk domain)
- rx_byte  in  8  received SPI byte
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  8  RAM write data
- wr_en  out  1  RAM write strobe, one write per high cycle
- busy  out  1  fill in progress
- err_opcode  out  1  sticky, unknown opcode seen
- err_range  out  1  sticky, start address ≥ FB_BYTES
- err_overrun  out  1  sticky, rx_valid received while busy

## Operation
- First byte of a transaction is the opcode: 0x01 WRITE, 0x02 FILL, 0x03 CLEAR_STATUS.
- WRITE carries addr_hi, addr_lo, then N data bytes. Data byte k is written to start+k. The address wraps from FB_BYTES-1 to 0. N is unbounded.
- WRITE with start ≥ FB_BYTES sets err_range. The remaining bytes are discarded.
- FILL carries one value byte. The block then writes that value to addresses 0..FB_BYTES-1 in ascending order, one per cycle.
- CLEAR_STATUS clears all three error flags. Any following bytes are discarded.
- Any other opcode sets err_opcode. The rest of the transaction is discarded.
- States:
  - IDLE: on rx_valid, decode the opcode and go to ADDR_HI, FILL_VAL or DISCARD.
  - ADDR_HI: on rx_valid, go to ADDR_LO.
  - ADDR_LO: on rx_valid, go to DATA, or to DISCARD if out of range.
  - DATA: stays in DATA.
  - FILL_VAL: on rx_valid, go to FILLING.
  - FILLING: after FB_BYTES writes, go to IDLE.
  - DISCARD: remains until cs_n deasserts.
- Synchronised cs_n high forces IDLE from every state except FILLING. A fill always completes.
- rx_valid in the same cycle as synchronised cs_n high: the byte is still processed (DATA write issued), then the state goes to IDLE.
- rx_valid while FILLING: the byte is dropped and err_overrun is set. After the fill, the block returns to IDLE, or to DISCARD if cs_n is still low.
- Address arithmetic is ADDR_W-bit, with explicit compare-and-wrap at FB_BYTES-1. Natural 2^ADDR_W overflow is never relied on.

## Timing
- Reset values: wr_addr=0, wr_data=0, wr_en=0, busy=0, all err_*=0, state IDLE, cs sync flops=1.
- All outputs are registered.
- WRITE: data rx_valid at cycle t gives wr_en=1 at t+1 with that byte and address. wr_en pulses once per data byte. Back-to-back rx_valid gives back-to-back writes.
- FILL: value rx_valid at t gives busy=1 and wr_en=1 from t+1 through t+FB_BYTES. wr_addr runs 0..FB_BYTES-1. busy=0 and wr_en=0 at t+FB_BYTES+1.
- Error flags set in the cycle after the offending rx_valid.
- cs_n to internal effect: 2–3 clk latency.
- Reset mid-fill: outputs go to reset values immediately and asynchronously. No further writes occur.

## Test plan
- WRITE at 0x0010: cs low, bytes 01 00 10 AA BB CC, cs high -> three wr_en pulses: (0x0010,AA), (0x0011,BB), (0x0012,CC). No errors.
- Wrap: 01 95 FF 11 22 (start 38399) -> writes (38399,0x11) then (0,0x22).
- Range: 01 96 00 55 (start 38400) -> no wr_en, err_range=1 next cycle. A new transaction after cs high works normally.
- FILL: 02 F0 -> exactly 38400 consecutive wr_en cycles, addresses 0..38399, data F0, busy high throughout. Extra byte sent mid-fill sets err_overrun and does not alter the fill.
- Abort and bad opcode: 01 12 then cs high, then 01 00 00 77 -> only (0x0000,77) written. A 0x7E opcode sets err_opcode; 03 clears it.
- Async reset asserted during FILL at address ~1000 -> wr_en and busy fall without a clock edge. After release: IDLE, no writes.

Source files
------------

// File: rtl/spi_frame_loader.sv
// SPI command decoder feeding the screen RAM write port: streamed byte writes at an
// auto-incrementing, wrapping address, or a full-framebuffer hardware fill.
module spi_frame_loader #(
  parameter int FB_BYTES = 38400,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              err_opcode,
  output logic              err_range,
  output logic              err_overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_FILL  = 8'h02;
  localparam logic [7:0] OP_CLEAR = 8'h03;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR_HI  = 3'd1,
    ADDR_LO  = 3'd2,
    DATA     = 3'd3,
    FILL_VAL = 3'd4,
    FILLING  = 3'd5,
    DISCARD  = 3'd6
  } state_t;

  // Explicit compare-and-wrap so the framebuffer size need not be a power of two.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    if (a == LAST_ADDR) begin
      r = {ADDR_W{1'b0}};
    end else begin
      r = a + ADDR_W'(1);
    end
    return r;
  endfunction

  logic              cs_meta_r, cs_sync_r;
  state_t            state_r, state_s;
  logic [7:0]        addr_hi_r, addr_hi_s;
  logic [ADDR_W-1:0] ptr_r, ptr_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
  logic [7:0]        wr_data_r, wr_data_s;
  logic              wr_en_r, wr_en_s;
  logic              busy_r, busy_s;
  logic              err_opcode_r, err_opcode_s;
  logic              err_range_r, err_range_s;
  logic              err_overrun_r, err_overrun_s;
  logic [15:0]       start_s;
  logic              start_ok_s;

  assign start_s    = {addr_hi_r, rx_byte};
  assign start_ok_s = (32'(start_s) < 32'(FB_BYTES));

  // Two-flop synchroniser for the raw chip select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_meta_r <= 1'b1;
      cs_sync_r <= 1'b1;
    end else begin
      cs_meta_r <= cs_n;
      cs_sync_r <= cs_meta_r;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_s       = state_r;
    addr_hi_s     = addr_hi_r;
    ptr_s         = ptr_r;
    wr_addr_s     = wr_addr_r;
    wr_data_s     = wr_data_r;
    wr_en_s       = 1'b0;
    busy_s        = 1'b0;
    err_opcode_s  = err_opcode_r;
    err_range_s   = err_range_r;
    err_overrun_s = err_overrun_r;

    case (state_r)
      IDLE: begin
        if (rx_valid) begin
          case (rx_byte)
            OP_WRITE: state_s = ADDR_HI;
            OP_FILL:  state_s = FILL_VAL;
            OP_CLEAR: begin
              err_opcode_s  = 1'b0;
              err_range_s   = 1'b0;
              err_overrun_s = 1'b0;
              state_s       = DISCARD;
            end
            default: begin
              err_opcode_s = 1'b1;
              state_s      = DISCARD;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      ADDR_HI: begin
        if (rx_valid) begin
          addr_hi_s = rx_byte;
          state_s   = ADDR_LO;
        end else begin
          state_s = ADDR_HI;
        end
      end
      ADDR_LO: begin
        if (rx_valid && start_ok_s) begin
          ptr_s   = ADDR_W'(start_s);
          state_s = DATA;
        end else if (rx_valid) begin
          err_range_s = 1'b1;
          state_s     = DISCARD;
        end else begin
          state_s = ADDR_LO;
        end
      end
      DATA: begin
        if (rx_valid) begin
          wr_en_s   = 1'b1;
          wr_addr_s = ptr_r;
          wr_data_s = rx_byte;
          ptr_s     = next_addr(ptr_r);
        end else begin
          ptr_s = ptr_r;
        end
      end
      FILL_VAL: begin
        if (rx_valid) begin
          wr_en_s   = 1'b1;
          busy_s    = 1'b1;
          wr_addr_s = {ADDR_W{1'b0}};
          wr_data_s = rx_byte;
          state_s   = FILLING;
        end else begin
          state_s = FILL_VAL;
        end
      end
      FILLING: begin
        if (rx_valid) begin
          err_overrun_s = 1'b1;
        end else begin
          err_overrun_s = err_overrun_r;
        end
        // wr_addr doubles as the fill counter; the last address ends the fill.
        if (wr_addr_r == LAST_ADDR) begin
          state_s = cs_sync_r ? IDLE : DISCARD;
        end else begin
          wr_en_s   = 1'b1;
          busy_s    = 1'b1;
          wr_addr_s = wr_addr_r + ADDR_W'(1);
        end
      end
      DISCARD: state_s = DISCARD;
      default: state_s = IDLE;
    endcase

    // Deselect aborts everything except a fill, which always runs to completion.
    if (cs_sync_r && (state_r != FILLING) && (state_s != FILLING)) begin
      state_s = IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      addr_hi_r     <= 8'h00;
      ptr_r         <= {ADDR_W{1'b0}};
      wr_addr_r     <= {ADDR_W{1'b0}};
      wr_data_r     <= 8'h00;
      wr_en_r       <= 1'b0;
      busy_r        <= 1'b0;
      err_opcode_r  <= 1'b0;
      err_range_r   <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      addr_hi_r     <= addr_hi_s;
      ptr_r         <= ptr_s;
      wr_addr_r     <= wr_addr_s;
      wr_data_r     <= wr_data_s;
      wr_en_r       <= wr_en_s;
      busy_r        <= busy_s;
      err_opcode_r  <= err_opcode_s;
      err_range_r   <= err_range_s;
      err_overrun_r <= err_overrun_s;
    end
  end

  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;
  assign wr_en       = wr_en_r;
  assign busy        = busy_r;
  assign err_opcode  = err_opcode_r;
  assign err_range   = err_range_r;
  assign err_overrun = err_overrun_r;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader: expected RAM writes are queued as bytes are sent
// and a negedge monitor pops and compares every wr_en cycle.
module tb_spi_frame_loader;

  localparam int FB = 38400;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs_n = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_en, busy, err_opcode, err_range, err_overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [23:0] exp_q[$];
  logic fill_chk = 1'b0;
  logic ignore_writes = 1'b0;

  spi_frame_loader #(.FB_BYTES(FB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy),
    .err_opcode(err_opcode), .err_range(err_range), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every wr_en cycle must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && wr_en && !ignore_writes) begin
      if (exp_q.size() == 0) begin
        check("spurious_wr_en", 32'(wr_en), 32'd0);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e[23:8]));
        check("wr_data", 32'(wr_data), 32'(e[7:0]));
        if (fill_chk) check("fill_busy", 32'(busy), 32'd1);
        if (exp_q.size() == 0) fill_chk = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic cs_high();
    @(posedge clk);
    #1 cs_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input logic [7:0] d);
    exp_q.push_back({16'(a), d});
  endtask

  task automatic wait_not_busy();
    for (int i = 0; i < FB + 100 && busy; i++) @(posedge clk);
    #1 check("fill_done_in_budget", 32'(busy), 32'd0);
  endtask

  initial begin
    #1;
    check("rst_outputs", {wr_addr, wr_data, 4'h0, wr_en, busy, err_opcode, err_range, err_overrun},
          32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Streamed write at 0x0010
    cs_low();
    push(16'h0010, 8'hAA); push(16'h0011, 8'hBB); push(16'h0012, 8'hCC);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    cs_high();
    check("write_all_seen", 32'(exp_q.size()), 32'd0);
    check("write_no_errs", {29'd0, err_opcode, err_range, err_overrun}, 32'd0);

    // Wrap from the last address to 0
    cs_low();
    push(FB - 1, 8'h11); push(0, 8'h22);
    send_byte(8'h01); send_byte(8'h95); send_byte(8'hFF);
    send_byte(8'h11); send_byte(8'h22);
    cs_high();
    check("wrap_all_seen", 32'(exp_q.size()), 32'd0);

    // Out-of-range start address
    cs_low();
    send_byte(8'h01); send_byte(8'h96);
    check("range_before", 32'(err_range), 32'd0);
    send_byte(8'h00);
    check("range_set", 32'(err_range), 32'd1);
    send_byte(8'h55);
    cs_high();
    cs_low();
    push(5, 8'h66);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h05); send_byte(8'h66);
    cs_high();
    check("after_range_write", 32'(exp_q.size()), 32'd0);

    // Full fill with an overrun byte injected mid-way
    cs_low();
    for (int i = 0; i < FB; i++) push(i, 8'hF0);
    send_byte(8'h02);
    send_byte(8'hF0);
    fill_chk = 1'b1;
    check("fill_busy_start", 32'(busy), 32'd1);
    repeat (100) @(posedge clk);
    #1 check("overrun_before", 32'(err_overrun), 32'd0);
    send_byte(8'h99);
    check("overrun_set", 32'(err_overrun), 32'd1);
    wait_not_busy();
    check("fill_all_seen", 32'(exp_q.size()), 32'd0);
    check("fill_wr_en_low", 32'(wr_en), 32'd0);
    send_byte(8'h12);
    cs_high();

    // Aborted write header, then a fresh write at 0
    cs_low();
    send_byte(8'h01); send_byte(8'h12);
    cs_high();
    cs_low();
    push(0, 8'h77);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h77);
    cs_high();
    check("abort_all_seen", 32'(exp_q.size()), 32'd0);

    // Unknown opcode then CLEAR_STATUS
    cs_low();
    send_byte(8'h7E);
    check("opcode_err", 32'(err_opcode), 32'd1);
    cs_high();
    check("errs_sticky", {29'd0, err_opcode, err_range, err_overrun}, 32'd7);
    cs_low();
    send_byte(8'h03);
    check("errs_cleared", {29'd0, err_opcode, err_range, err_overrun}, 32'd0);
    cs_high();

    // Asynchronous reset in the middle of a fill
    cs_low();
    ignore_writes = 1'b1;
    send_byte(8'h02); send_byte(8'hAB);
    repeat (1000) @(posedge clk);
    #1 check("mid_fill_active", {30'd0, wr_en, busy}, 32'd3);
    #2 rst = 1'b1;
    #1 check("async_rst_outputs", {wr_addr, wr_data, 6'd0, wr_en, busy}, 32'd0);
    cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ignore_writes = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("post_rst_idle", {30'd0, wr_en, busy}, 32'd0);
    check("post_rst_no_writes", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
